// File: rtl/ni_local_port.sv
// Network interface between a PE and a router Local port: packetises PE requests
// into flits for injection, buffers ejected flits for the PE, and keeps statistics.
module ni_local_port #(
  parameter int DATASIZE = 40,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          ID,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [3:0]          tx_dst,
  input  logic [21:0]         tx_payload,
  input  logic [1:0]          tx_type,
  output logic [DATASIZE-1:0] L_data_in,
  output logic                L_valid_in,
  input  logic                full,
  input  logic [DATASIZE-1:0] L_data_out,
  input  logic                L_valid_out,
  output logic                L_full_in,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [3:0]          rx_src,
  output logic [21:0]         rx_payload,
  output logic [1:0]          rx_type,
  output logic [7:0]          rx_latency,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count,
  output logic                misroute
);
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int RX_W  = 36;  // {src, payload, type, latency}

  typedef enum logic [1:0] {FC_EMPTY, FC_PARTIAL, FC_FULL} fc_state_e;

  function automatic fc_state_e fc_next(fc_state_e st, logic up, logic down, int cnt, int depth);
    fc_state_e nx;
    nx = st;
    if (up && !down)      nx = (cnt + 1 == depth) ? FC_FULL : FC_PARTIAL;
    else if (down && !up) nx = (cnt == 1) ? FC_EMPTY : FC_PARTIAL;
    return nx;
  endfunction

  logic [7:0]          ts_q, ts_d;
  logic [DATASIZE-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_PW-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_PW:0]      tx_cnt_q, tx_cnt_d;
  fc_state_e           tx_st_q, tx_st_d;
  logic [RX_W-1:0]     rx_mem_q [RX_DEPTH];
  logic [RX_PW-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_PW:0]      rx_cnt_q, rx_cnt_d;
  fc_state_e           rx_st_q, rx_st_d;
  logic [15:0]         tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic                misroute_q, misroute_d;
  logic                tx_push, tx_pop, rx_acc, rx_pop;
  logic [DATASIZE-1:0] tx_wdata;
  logic [RX_W-1:0]     rx_wdata, rx_head;

  assign tx_ready   = (tx_st_q != FC_FULL);
  assign L_valid_in = (tx_st_q != FC_EMPTY);
  assign L_data_in  = L_valid_in ? tx_mem_q[tx_rd_q] : '0;
  assign L_full_in  = (rx_st_q == FC_FULL);
  assign rx_valid   = (rx_st_q != FC_EMPTY);
  assign rx_head    = rx_valid ? rx_mem_q[rx_rd_q] : '0;
  assign {rx_src, rx_payload, rx_type, rx_latency} = rx_head;
  assign tx_count   = tx_count_q;
  assign rx_count   = rx_count_q;
  assign misroute   = misroute_q;

  always_comb begin
    tx_push    = tx_valid && tx_ready;
    tx_pop     = L_valid_in && !full;
    rx_acc     = L_valid_out && !L_full_in;
    rx_pop     = rx_valid && rx_ready;
    tx_wdata   = {ID, tx_dst, ts_q, tx_payload, tx_type};
    // Latency is taken modulo 256 so a timestamp wrap in flight still reads correctly.
    rx_wdata   = {L_data_out[39:36], L_data_out[23:2], L_data_out[1:0], ts_q - L_data_out[31:24]};
    ts_d       = ts_q + 8'd1;
    tx_wr_d    = tx_push ? tx_wr_q + TX_PW'(1) : tx_wr_q;
    tx_rd_d    = tx_pop  ? tx_rd_q + TX_PW'(1) : tx_rd_q;
    rx_wr_d    = rx_acc  ? rx_wr_q + RX_PW'(1) : rx_wr_q;
    rx_rd_d    = rx_pop  ? rx_rd_q + RX_PW'(1) : rx_rd_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + (TX_PW+1)'(1);
    if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - (TX_PW+1)'(1);
    if (rx_acc && !rx_pop)  rx_cnt_d = rx_cnt_q + (RX_PW+1)'(1);
    if (rx_pop && !rx_acc)  rx_cnt_d = rx_cnt_q - (RX_PW+1)'(1);
    tx_st_d    = fc_next(tx_st_q, tx_push, tx_pop, int'(tx_cnt_q), TX_DEPTH);
    rx_st_d    = fc_next(rx_st_q, rx_acc, rx_pop, int'(rx_cnt_q), RX_DEPTH);
    tx_count_d = tx_pop ? tx_count_q + 16'd1 : tx_count_q;
    rx_count_d = rx_acc ? rx_count_q + 16'd1 : rx_count_q;
    misroute_d = misroute_q | (rx_acc && (L_data_out[35:32] != ID));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ts_q       <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_st_q    <= FC_EMPTY;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      rx_st_q    <= FC_EMPTY;
      tx_count_q <= '0;
      rx_count_q <= '0;
      misroute_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_st_q    <= tx_st_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_st_q    <= rx_st_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      misroute_q <= misroute_d;
    end
  end

  // Storage is not cleared; reset empties the FIFOs through the pointers and counts.
  always_ff @(posedge clk) begin
    if (!rst_n && tx_push) tx_mem_q[tx_wr_q] <= tx_wdata;
    if (!rst_n && rx_acc)  rx_mem_q[rx_wr_q] <= rx_wdata;
  end
endmodule

// File: tb/tb_ni_local_port.sv
// Randomised and directed checks of ni_local_port against a queue-based model
// of the injection and ejection paths.
module tb_ni_local_port;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ID;
  logic        tx_valid, tx_ready;
  logic [3:0]  tx_dst;
  logic [21:0] tx_payload;
  logic [1:0]  tx_type;
  logic [39:0] L_data_in, L_data_out;
  logic        L_valid_in, full, L_valid_out, L_full_in;
  logic        rx_valid, rx_ready;
  logic [3:0]  rx_src;
  logic [21:0] rx_payload;
  logic [1:0]  rx_type;
  logic [7:0]  rx_latency;
  logic [15:0] tx_count, rx_count;
  logic        misroute;

  ni_local_port #(.DATASIZE(40), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .ID(ID),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst),
    .tx_payload(tx_payload), .tx_type(tx_type),
    .L_data_in(L_data_in), .L_valid_in(L_valid_in), .full(full),
    .L_data_out(L_data_out), .L_valid_out(L_valid_out), .L_full_in(L_full_in),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src),
    .rx_payload(rx_payload), .rx_type(rx_type), .rx_latency(rx_latency),
    .tx_count(tx_count), .rx_count(rx_count), .misroute(misroute)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFOs as queues, statistics as plain counters.
  logic [39:0] m_tx[$];
  logic [35:0] m_rx[$];
  logic [7:0]  m_ts;
  logic [15:0] m_txc, m_rxc;
  logic        m_mis;

  logic [112:0] act_vec;
  assign act_vec = {tx_ready, L_valid_in, L_data_in, L_full_in, rx_valid, rx_src,
                    rx_payload, rx_type, rx_latency, tx_count, rx_count, misroute};

  function automatic logic [112:0] exp_vec();
    logic [39:0] th;
    logic [35:0] rh;
    th = (m_tx.size() != 0) ? m_tx[0] : 40'd0;
    rh = (m_rx.size() != 0) ? m_rx[0] : 36'd0;
    return {m_tx.size() < TXD, m_tx.size() != 0, th, m_rx.size() == RXD,
            m_rx.size() != 0, rh, m_txc, m_rxc, m_mis};
  endfunction

  // One clock: inputs were set at the previous falling edge; model follows the
  // rising edge; return at the next falling edge for sampling.
  task automatic cycle();
    bit pop, push, acc, rpop;
    @(posedge clk);
    if (rst_n) begin
      m_tx.delete(); m_rx.delete();
      m_ts = 8'd0; m_txc = 16'd0; m_rxc = 16'd0; m_mis = 1'b0;
    end else begin
      pop  = (m_tx.size() != 0) && !full;
      push = tx_valid && (m_tx.size() < TXD);
      acc  = L_valid_out && (m_rx.size() < RXD);
      rpop = (m_rx.size() != 0) && rx_ready;
      if (pop) begin void'(m_tx.pop_front()); m_txc++; end
      if (push) m_tx.push_back({ID, tx_dst, m_ts, tx_payload, tx_type});
      if (rpop) void'(m_rx.pop_front());
      if (acc) begin
        m_rx.push_back({L_data_out[39:36], L_data_out[23:2], L_data_out[1:0], m_ts - L_data_out[31:24]});
        m_rxc++;
        if (L_data_out[35:32] != ID) m_mis = 1'b1;
      end
      m_ts++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tx_valid = 0; tx_dst = 0; tx_payload = 0; tx_type = 0;
    full = 0; L_valid_out = 0; L_data_out = 0; rx_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1; cycle(); rst_n = 0;
  endtask

  task automatic test_reset();
    tx_valid = 1; L_valid_out = 1; L_data_out = 40'h123456789A;
    rst_n = 1; cycle(); rst_n = 0; idle_inputs();
    n_vec++;
    if (act_vec !== {1'b1, 112'd0}) begin
      n_err++; $display("FAIL reset_state: got %h want %h", act_vec, {1'b1, 112'd0});
    end
    $display("test_reset: outputs after reset %h", act_vec);
  endtask

  task automatic test_single_inject();
    do_reset();
    while (m_ts != 8'h10) cycle();
    tx_valid = 1; tx_dst = 4'd9; tx_payload = 22'h155555; tx_type = 2'd2;
    cycle(); tx_valid = 0;
    n_vec++;
    if ({L_valid_in, L_data_in} !== {1'b1, 40'h3910555556}) begin
      n_err++; $display("FAIL inject_flit: got v=%b d=%h want v=1 d=3910555556", L_valid_in, L_data_in);
    end
    cycle();
    n_vec++;
    if ({tx_count, L_valid_in} !== {16'd1, 1'b0}) begin
      n_err++; $display("FAIL inject_count: got cnt=%0d v=%b want cnt=1 v=0", tx_count, L_valid_in);
    end
    $display("test_single_inject: flit sent, tx_count=%0d", tx_count);
  endtask

  task automatic test_backpressure();
    logic [39:0] fl[TXD];
    do_reset();
    full = 1;
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1; tx_dst = 4'($urandom); tx_payload = 22'($urandom); tx_type = 2'($urandom);
      cycle();
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL bp_fill[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
      if (i == 0) fl[0] = m_tx[0];
      n_vec++;
      if (L_data_in !== fl[0]) begin
        n_err++; $display("FAIL bp_stable[%0d]: got %h want %h", i, L_data_in, fl[0]);
      end
    end
    n_vec++;
    if (tx_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready: got %b want 0", tx_ready);
    end
    for (int i = 0; i < TXD; i++) fl[i] = m_tx[i];
    tx_valid = 0; full = 0;
    for (int i = 0; i < TXD; i++) begin
      n_vec++;
      if ({L_valid_in, L_data_in} !== {1'b1, fl[i]}) begin
        n_err++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, L_valid_in, L_data_in, fl[i]);
      end
      $display("test_backpressure: flit %0d out %h", i, L_data_in);
      cycle();
    end
    n_vec++;
    if ({tx_count, L_valid_in} !== {16'd4, 1'b0}) begin
      n_err++; $display("FAIL bp_count: got cnt=%0d v=%b want cnt=4 v=0", tx_count, L_valid_in);
    end
  endtask

  task automatic test_eject_wrap();
    logic [21:0] p;
    do_reset();
    while (m_ts != 8'h03) cycle();
    p = 22'($urandom);
    L_valid_out = 1; L_data_out = {4'h7, 4'h3, 8'hFE, p, 2'h1};
    cycle(); L_valid_out = 0;
    n_vec++;
    if ({rx_valid, rx_latency, rx_src, rx_payload, rx_type, rx_count} !== {1'b1, 8'h05, 4'h7, p, 2'h1, 16'd1}) begin
      n_err++; $display("FAIL eject_wrap: got lat=%h src=%h pl=%h ty=%0d cnt=%0d want lat=05 src=7 pl=%h ty=1 cnt=1",
                        rx_latency, rx_src, rx_payload, rx_type, rx_count, p);
    end
    $display("test_eject_wrap: latency %h", rx_latency);
  endtask

  task automatic test_rx_full();
    logic [39:0] nf;
    do_reset();
    for (int i = 0; i < RXD; i++) begin
      L_valid_out = 1; L_data_out = {4'($urandom), ID, 8'($urandom), 22'($urandom), 2'($urandom)};
      cycle();
    end
    n_vec++;
    if ({L_full_in, rx_count} !== {1'b1, 16'd4}) begin
      n_err++; $display("FAIL rx_full: got full=%b cnt=%0d want full=1 cnt=4", L_full_in, rx_count);
    end
    // Router holds its flit until the slot freed by the one-cycle pop is taken.
    nf = {4'hA, ID, 8'h00, 22'h2AAAAA, 2'h3};
    L_data_out = nf; rx_ready = 1;
    cycle(); rx_ready = 0;
    cycle(); L_valid_out = 0;
    n_vec++;
    if (act_vec !== exp_vec() || L_full_in !== 1'b1) begin
      n_err++; $display("FAIL rx_refill: got %h want %h", act_vec, exp_vec());
    end
    rx_ready = 1;
    for (int i = 0; i < RXD; i++) begin
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL rx_drain[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
      if (i == RXD - 1) begin
        n_vec++;
        if ({rx_src, rx_payload, rx_type} !== {4'hA, 22'h2AAAAA, 2'h3}) begin
          n_err++; $display("FAIL rx_tail: got src=%h pl=%h ty=%0d want src=a pl=2aaaaa ty=3", rx_src, rx_payload, rx_type);
        end
      end
      $display("test_rx_full: pop src=%h payload=%h", rx_src, rx_payload);
      cycle();
    end
    rx_ready = 0;
  endtask

  task automatic test_misroute();
    do_reset();
    L_valid_out = 1; rx_ready = 1;
    L_data_out = {4'h1, 4'h5, 8'h00, 22'h1234, 2'h0};
    cycle();
    n_vec++;
    if (misroute !== 1'b1) begin
      n_err++; $display("FAIL misroute_set: got %b want 1", misroute);
    end
    for (int i = 0; i < 3; i++) begin
      L_data_out = {4'($urandom), ID, 8'($urandom), 22'($urandom), 2'($urandom)};
      cycle();
      n_vec++;
      if (misroute !== 1'b1) begin
        n_err++; $display("FAIL misroute_sticky[%0d]: got %b want 1", i, misroute);
      end
    end
    do_reset();
    n_vec++;
    if (misroute !== 1'b0) begin
      n_err++; $display("FAIL misroute_clear: got %b want 0", misroute);
    end
    $display("test_misroute: sticky flag cleared by reset");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    full = 1; rx_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1; tx_dst = 4'($urandom); tx_payload = 22'($urandom); tx_type = 2'($urandom);
      L_valid_out = 1; L_data_out = {4'($urandom), ID, 8'($urandom), 22'($urandom), 2'($urandom)};
      cycle();
    end
    rst_n = 1; cycle(); rst_n = 0;
    tx_valid = 0; L_valid_out = 0;
    n_vec++;
    if ({L_valid_in, rx_valid, tx_count, rx_count, tx_ready, L_full_in} !== {1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_midflight: got lv=%b rv=%b tc=%0d rc=%0d rdy=%b lf=%b want 0 0 0 0 1 0",
                        L_valid_in, rx_valid, tx_count, rx_count, tx_ready, L_full_in);
    end
    n_vec++;
    if (act_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_midflight_all: got %h want %h", act_vec, exp_vec());
    end
    $display("test_reset_midflight: both paths emptied");
  endtask

  task automatic test_random();
    do_reset();
    ID = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      tx_valid    = ($urandom_range(0, 2) != 0);
      tx_dst      = 4'($urandom);
      tx_payload  = 22'($urandom);
      tx_type     = 2'($urandom);
      full        = ($urandom_range(0, 3) == 0);
      L_valid_out = ($urandom_range(0, 1) != 0);
      L_data_out  = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) != 0) L_data_out[35:32] = ID;
      rx_ready    = ($urandom_range(0, 2) != 0);
      cycle();
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
    end
    idle_inputs();
    $display("test_random: tx_count=%0d rx_count=%0d", tx_count, rx_count);
    ID = 4'd3;
  endtask

  initial begin
    rst_n = 1; ID = 4'd3;
    idle_inputs();
    m_ts = 0; m_txc = 0; m_rxc = 0; m_mis = 0;
    test_reset();
    test_single_inject();
    test_backpressure();
    test_eject_wrap();
    test_rx_full();
    test_misroute();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
